// File: rtl/writeback_stage_if.sv
// Bus between the memory stage, writeback_stage and its consumers
// (register-file write port, scoreboard clear and decode bypass).
interface writeback_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  memory_done;
  logic [XLEN-1:0]       alu_data;
  logic [XLEN-1:0]       loaded_data_raw;
  logic [REG_ADDR_W-1:0] rd;
  logic                  reg_write;
  logic                  mem_to_reg;
  logic [2:0]            data_size;

  logic                  mem_wb_pipeline_valid;
  logic                  rf_write_en;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic [XLEN-1:0]       rf_write_data;
  logic                  sb_clear;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [XLEN-1:0]       fwd_data;

  modport master (
    output memory_done, alu_data, loaded_data_raw, rd, reg_write, mem_to_reg, data_size,
    input  mem_wb_pipeline_valid, rf_write_en, rf_write_addr, rf_write_data, sb_clear,
           fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  memory_done, alu_data, loaded_data_raw, rd, reg_write, mem_to_reg, data_size,
    output mem_wb_pipeline_valid, rf_write_en, rf_write_addr, rf_write_data, sb_clear,
           fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: four-phase capture of a memory-stage result, load extraction and
// register-file write. Optional decode bypass enabled by defining WB_FORWARD_EN.
module writeback_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input logic               clk,
  input logic               reset,
  writeback_stage_if.slave  bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WRITE    = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  capture;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       raw_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;
  logic                  mem_to_reg_q;
  logic [2:0]            size_q;

  logic [2:0]            offset;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_value;
  logic [XLEN-1:0]       wb_value;
  logic                  wr_ok;
  logic                  write_fire;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.memory_done) begin
          state_d = WRITE;
          capture = 1'b1;
        end
      end
      WRITE:    state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.memory_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_q        <= '0;
      raw_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      size_q       <= 3'b000;
    end else begin
      state_q <= state_d;
      if (capture) begin
        alu_q        <= bus.alu_data;
        raw_q        <= bus.loaded_data_raw;
        rd_q         <= bus.rd;
        reg_write_q  <= bus.reg_write;
        mem_to_reg_q <= bus.mem_to_reg;
        size_q       <= bus.data_size;
      end
    end
  end

  // Misaligned offsets are rounded down to the access size before the byte shift.
  always_comb begin
    case (size_q[1:0])
      2'b00:   offset = alu_q[2:0];
      2'b01:   offset = {alu_q[2:1], 1'b0};
      2'b10:   offset = {alu_q[2], 2'b00};
      default: offset = 3'b000;
    endcase
    shifted = raw_q >> {offset, 3'b000};
    case (size_q)
      3'b000:  load_value = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b011:  load_value = shifted;
      3'b100:  load_value = {{(XLEN-8){1'b0}},  shifted[7:0]};
      3'b101:  load_value = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b110:  load_value = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_value = '0;
    endcase
    wb_value = mem_to_reg_q ? load_value : alu_q;
  end

  // Reset gates the strobe directly so a reset landing in WRITE suppresses the write.
  assign wr_ok      = reg_write_q && (rd_q != '0);
  assign write_fire = (state_q == WRITE) && wr_ok && !reset;

  assign bus.mem_wb_pipeline_valid = (state_q != IDLE);
  assign bus.rf_write_en           = write_fire;
  assign bus.sb_clear              = write_fire;
  assign bus.rf_write_addr         = write_fire ? rd_q : '0;
  assign bus.rf_write_data         = write_fire ? wb_value : '0;

`ifdef WB_FORWARD_EN
  logic fwd_on;
  assign fwd_on        = write_fire || ((state_q == WAIT_LOW) && wr_ok);
  assign bus.fwd_valid = fwd_on;
  assign bus.fwd_rd    = fwd_on ? rd_q : '0;
  assign bus.fwd_data  = fwd_on ? wb_value : '0;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rd    = '0;
  assign bus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_writeback_stage;
  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;
  int   writesSeen;
  bit   checking;

  writeback_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

  writeback_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the transaction currently being acknowledged.
  bit          mBusy;
  bit          mFresh;
  logic [4:0]  mRd;
  bit          mWr;
  logic [63:0] mValue;

  function automatic logic [63:0] expectedValue(logic [63:0] alu, logic [63:0] raw,
                                                int size, bit m2r);
    int          bytes;
    int          off;
    logic [63:0] v;
    logic [63:0] mask;
    if (!m2r) return alu;
    if (size == 7) return 64'd0;
    bytes = 1 << (size % 4);
    off   = int'(alu % 8);
    off   = off - (off % bytes);
    v     = raw >> (8 * off);
    if (bytes == 8) return v;
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    v    = v & mask;
    if (size < 4 && v[8*bytes-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(bit rst, bit md, logic [63:0] alu, logic [63:0] raw,
                               logic [4:0] rdv, bit rw, bit m2r, logic [2:0] size);
    reset                   = rst;
    bus.memory_done         = md;
    bus.alu_data            = alu;
    bus.loaded_data_raw     = raw;
    bus.rd                  = rdv;
    bus.reg_write           = rw;
    bus.mem_to_reg          = m2r;
    bus.data_size           = size;
    @(posedge clk);
    if (rst) begin
      mBusy  = 0;
      mFresh = 0;
      mRd    = '0;
      mWr    = 0;
      mValue = '0;
    end else if (!mBusy) begin
      if (md) begin
        mBusy  = 1;
        mFresh = 1;
        mRd    = rdv;
        mWr    = rw;
        mValue = expectedValue(alu, raw, int'(size), m2r);
      end
    end else if (mFresh) begin
      mFresh = 0;
    end else if (!md) begin
      mBusy = 0;
    end
    @(negedge clk);
    #1;
  endtask

  bit          wantWrite;
  bit          okRd;
  bit          fwdOn;
  always @(negedge clk) begin
    if (checking) begin
      okRd      = mWr && (mRd != 5'd0);
      wantWrite = mFresh && okRd && !reset;
      checkOutput("valid", {63'd0, bus.mem_wb_pipeline_valid}, {63'd0, mBusy});
      checkOutput("wen",   {63'd0, bus.rf_write_en}, {63'd0, wantWrite});
      checkOutput("sb_clear", {63'd0, bus.sb_clear}, {63'd0, wantWrite});
      checkOutput("waddr", {59'd0, bus.rf_write_addr}, wantWrite ? {59'd0, mRd} : 64'd0);
      checkOutput("wdata", bus.rf_write_data, wantWrite ? mValue : 64'd0);
`ifdef WB_FORWARD_EN
      fwdOn = mFresh ? wantWrite : (mBusy && okRd);
`else
      fwdOn = 0;
`endif
      checkOutput("fwd_valid", {63'd0, bus.fwd_valid}, {63'd0, fwdOn});
      checkOutput("fwd_rd", {59'd0, bus.fwd_rd}, fwdOn ? {59'd0, mRd} : 64'd0);
      checkOutput("fwd_data", bus.fwd_data, fwdOn ? mValue : 64'd0);
      if (bus.rf_write_en === 1'b1) writesSeen++;
    end
  end

  initial begin
    int snap;
    bit md;
    assertCount = 0;
    failCount   = 0;
    writesSeen  = 0;
    mBusy = 0; mFresh = 0; mRd = '0; mWr = 0; mValue = '0;
    checking = 1;

    applyStimulus(1, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    applyStimulus(1, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    checkOutput("reset valid", {63'd0, bus.mem_wb_pipeline_valid}, 64'd0);
    checkOutput("reset wen", {63'd0, bus.rf_write_en}, 64'd0);
    checkOutput("reset wdata", bus.rf_write_data, 64'd0);
    checkOutput("reset fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);

    // x0 destination: handshake completes, no write
    snap = writesSeen;
    applyStimulus(0, 1, 64'd5, 64'd0, 5'd0, 1, 0, 3'd0);
    checkOutput("x0 valid N+1", {63'd0, bus.mem_wb_pipeline_valid}, 64'd1);
    checkOutput("x0 wen", {63'd0, bus.rf_write_en}, 64'd0);
    applyStimulus(0, 1, 64'd5, 64'd0, 5'd0, 1, 0, 3'd0);
    applyStimulus(0, 0, 64'd5, 64'd0, 5'd0, 1, 0, 3'd0);
    checkOutput("x0 back idle", {63'd0, bus.mem_wb_pipeline_valid}, 64'd0);
    checkOutput("x0 no writes", 64'(writesSeen - snap), 64'd0);

    // ALU result
    applyStimulus(0, 1, 64'h1234, 64'd0, 5'd7, 1, 0, 3'd3);
    checkOutput("alu wen", {63'd0, bus.rf_write_en}, 64'd1);
    checkOutput("alu addr", {59'd0, bus.rf_write_addr}, 64'd7);
    checkOutput("alu data", bus.rf_write_data, 64'h1234);
    checkOutput("alu sb_clear", {63'd0, bus.sb_clear}, 64'd1);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    checkOutput("alu wen one cycle", {63'd0, bus.rf_write_en}, 64'd0);
    checkOutput("alu sb one cycle", {63'd0, bus.sb_clear}, 64'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);

    // LB / LBU at offset 2
    applyStimulus(0, 1, 64'd2, 64'h00000000_0080FF00, 5'd3, 1, 1, 3'b000);
    checkOutput("LB data", bus.rf_write_data, 64'hFFFFFFFF_FFFFFF80);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    applyStimulus(0, 1, 64'd2, 64'h00000000_0080FF00, 5'd3, 1, 1, 3'b100);
    checkOutput("LBU data", bus.rf_write_data, 64'h80);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);

    // LH at misaligned offset 3
    applyStimulus(0, 1, 64'd3, 64'h00000000_80010000, 5'd8, 1, 1, 3'b001);
    checkOutput("LH misaligned", bus.rf_write_data, 64'hFFFFFFFF_FFFF8001);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);

    // Back-to-back: high 4, low 1, high 2, low 2
    snap = writesSeen;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 64'd11, 64'd0, 5'd9, 1, 0, 3'd0);
    applyStimulus(0, 0, 64'd11, 64'd0, 5'd9, 1, 0, 3'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 64'd12, 64'd0, 5'd9, 1, 0, 3'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    checkOutput("back-to-back writes", 64'(writesSeen - snap), 64'd2);

    // Reset arriving during WRITE
    applyStimulus(0, 1, 64'h55, 64'd0, 5'd4, 1, 0, 3'd0);
    reset = 1'b1;
    #1;
    checkOutput("reset in WRITE wen", {63'd0, bus.rf_write_en}, 64'd0);
    checkOutput("reset in WRITE sb", {63'd0, bus.sb_clear}, 64'd0);
    applyStimulus(1, 1, 64'h55, 64'd0, 5'd4, 1, 0, 3'd0);
    checkOutput("after reset valid", {63'd0, bus.mem_wb_pipeline_valid}, 64'd0);
    checkOutput("after reset data", bus.rf_write_data, 64'd0);
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);

    // LD with bypass
    applyStimulus(0, 1, 64'd0, 64'hDEADBEEF_00000001, 5'd5, 1, 1, 3'b011);
    checkOutput("LD data", bus.rf_write_data, 64'hDEADBEEF_00000001);
`ifdef WB_FORWARD_EN
    checkOutput("fwd WRITE valid", {63'd0, bus.fwd_valid}, 64'd1);
    checkOutput("fwd WRITE data", bus.fwd_data, 64'hDEADBEEF_00000001);
    applyStimulus(0, 1, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
    checkOutput("fwd WAIT_LOW valid", {63'd0, bus.fwd_valid}, 64'd1);
    checkOutput("fwd WAIT_LOW data", bus.fwd_data, 64'hDEADBEEF_00000001);
`else
    checkOutput("fwd tied valid", {63'd0, bus.fwd_valid}, 64'd0);
    checkOutput("fwd tied data", bus.fwd_data, 64'd0);
    applyStimulus(0, 1, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);
`endif
    applyStimulus(0, 0, 64'd0, 64'd0, 5'd0, 0, 0, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      md = ($urandom_range(0, 9) < 6);
      applyStimulus(($urandom_range(0, 49) == 0), md,
                    {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    5'($urandom_range(0, 31)), bit'($urandom_range(0, 3) != 0),
                    bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
